// File: rtl/intl_fault_logger.sv
// -----------------------------------------------------------------------------
// intl_fault_logger
//
// Interlock event recorder. Watches the 32-bit interlock state word for bits
// that newly assert, stamps each such event with a free-running cycle counter
// and queues it in a small FIFO for software to drain. Independently latches
// the first event since the last interlock clear for root-cause diagnosis.
//
// Ports
//   i_clk          system clock (shared with the interlock core)
//   i_rst          asynchronous, active-low reset
//   i_intl_state   interlock state word (registered upstream)
//   i_intl_clr     interlock clear pulse, re-arms first-fault capture
//   i_log_flush    empties the FIFO and clears the overflow flag
//   i_pop          consume the FIFO head (ignored when empty)
//   o_ev_valid     FIFO holds at least one entry
//   o_ev_mask      head entry: bits that rose (0 when empty)
//   o_ev_time      head entry: timestamp (0 when empty)
//   o_ev_count     number of stored entries, 0..2**DEPTH_LOG2
//   o_overflow     sticky, an event was dropped on a full FIFO
//   o_first_valid  first-fault registers hold a capture
//   o_first_mask   rising bits of the first fault
//   o_first_time   timestamp of the first fault
//   o_timestamp    free-running cycle counter
// -----------------------------------------------------------------------------
module intl_fault_logger #(
   parameter int DEPTH_LOG2 = 4,
   parameter int TS_WIDTH   = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [31:0]           i_intl_state,
   input  logic                  i_intl_clr,
   input  logic                  i_log_flush,
   input  logic                  i_pop,
   output logic                  o_ev_valid,
   output logic [31:0]           o_ev_mask,
   output logic [TS_WIDTH-1:0]   o_ev_time,
   output logic [DEPTH_LOG2:0]   o_ev_count,
   output logic                  o_overflow,
   output logic                  o_first_valid,
   output logic [31:0]           o_first_mask,
   output logic [TS_WIDTH-1:0]   o_first_time,
   output logic [TS_WIDTH-1:0]   o_timestamp
);

   localparam int                DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

   logic [TS_WIDTH-1:0]   ts_p0;
   logic [31:0]           state_p0;
   logic [31:0]           rise;
   logic                  ev;

   logic [31:0]           mem_mask [DEPTH];
   logic [TS_WIDTH-1:0]   mem_time [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_p0;
   logic [DEPTH_LOG2-1:0] rd_ptr_p0;
   logic [DEPTH_LOG2:0]   cnt_p0;
   logic [DEPTH_LOG2:0]   cnt_nxt;
   logic                  ovf_p0;

   logic                  first_vld_p0;
   logic [31:0]           first_mask_p0;
   logic [TS_WIDTH-1:0]   first_time_p0;

   logic                  not_empty;
   logic                  full;
   logic                  do_pop;
   logic                  do_wr;
   logic                  drop;

   // ---- input stage: edge detect against previous state word ----
   assign rise = i_intl_state & ~state_p0;
   assign ev   = |rise;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_p0 <= '0;
         ts_p0    <= '0;
      end else begin
         // Previous state tracks every cycle, flush and clear included, so a
         // bit held high across a flush is not re-logged afterwards.
         state_p0 <= i_intl_state;
         ts_p0    <= ts_p0 + 1'b1;
      end
   end

   // ---- FIFO control: flush beats write/pop; a pop frees the slot a write
   //      into a full FIFO needs, so both can happen in one cycle ----
   assign not_empty = (cnt_p0 != '0);
   assign full      = (cnt_p0 == FULL_CNT);
   assign do_pop    = i_pop & not_empty;
   assign do_wr     = ev & (~full | do_pop);
   assign drop      = ev & full & ~do_pop;

   always_comb begin
      cnt_nxt = cnt_p0;
      if (do_wr && !do_pop) begin
         cnt_nxt = cnt_p0 + 1'b1;
      end else if (do_pop && !do_wr) begin
         cnt_nxt = cnt_p0 - 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         wr_ptr_p0 <= '0;
         rd_ptr_p0 <= '0;
         cnt_p0    <= '0;
         ovf_p0    <= 1'b0;
      end else if (i_log_flush) begin
         wr_ptr_p0 <= '0;
         rd_ptr_p0 <= '0;
         cnt_p0    <= '0;
         ovf_p0    <= 1'b0;
      end else begin
         if (do_wr) begin
            wr_ptr_p0 <= wr_ptr_p0 + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_p0 <= rd_ptr_p0 + 1'b1;
         end
         cnt_p0 <= cnt_nxt;
         if (drop) begin
            ovf_p0 <= 1'b1;
         end
      end
   end

   // ---- FIFO storage: when full and popping, the write slot equals the
   //      slot being vacated, which is safe because the head moves on ----
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_mask[i] <= '0;
            mem_time[i] <= '0;
         end
      end else if (!i_log_flush && do_wr) begin
         mem_mask[wr_ptr_p0] <= rise;
         mem_time[wr_ptr_p0] <= ts_p0;
      end
   end

   // ---- first-fault capture: clear-then-capture when both coincide ----
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         first_vld_p0  <= 1'b0;
         first_mask_p0 <= '0;
         first_time_p0 <= '0;
      end else if (ev && (i_intl_clr || !first_vld_p0)) begin
         first_vld_p0  <= 1'b1;
         first_mask_p0 <= rise;
         first_time_p0 <= ts_p0;
      end else if (i_intl_clr) begin
         first_vld_p0  <= 1'b0;
         first_mask_p0 <= '0;
         first_time_p0 <= '0;
      end
   end

   // ---- output stage ----
   assign o_ev_valid    = not_empty;
   assign o_ev_mask     = not_empty ? mem_mask[rd_ptr_p0] : '0;
   assign o_ev_time     = not_empty ? mem_time[rd_ptr_p0] : '0;
   assign o_ev_count    = cnt_p0;
   assign o_overflow    = ovf_p0;
   assign o_first_valid = first_vld_p0;
   assign o_first_mask  = first_mask_p0;
   assign o_first_time  = first_time_p0;
   assign o_timestamp   = ts_p0;

endmodule

// File: tb/tb_intl_fault_logger.sv
module tb_intl_fault_logger;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] state;
   logic        clr, flush, pop;

   logic        ev_valid;
   logic [31:0] ev_mask;
   logic [31:0] ev_time;
   logic [4:0]  ev_count;
   logic        overflow;
   logic        first_valid;
   logic [31:0] first_mask;
   logic [31:0] first_time;
   logic [31:0] timestamp;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   intl_fault_logger #(.DEPTH_LOG2(4), .TS_WIDTH(32)) dut (
      .i_clk        (clk),
      .i_rst        (rst_n),
      .i_intl_state (state),
      .i_intl_clr   (clr),
      .i_log_flush  (flush),
      .i_pop        (pop),
      .o_ev_valid   (ev_valid),
      .o_ev_mask    (ev_mask),
      .o_ev_time    (ev_time),
      .o_ev_count   (ev_count),
      .o_overflow   (overflow),
      .o_first_valid(first_valid),
      .o_first_mask (first_mask),
      .o_first_time (first_time),
      .o_timestamp  (timestamp)
   );

   // ---------------- behavioural reference model ----------------
   typedef struct {
      logic [31:0] mask;
      logic [31:0] ts;
   } ev_t;

   ev_t         m_q[$];
   logic [31:0] m_prev, m_ts, m_fm, m_ft;
   logic        m_ovf, m_fv;

   task automatic model_clear();
      m_q.delete();
      m_prev = 0; m_ts = 0; m_fm = 0; m_ft = 0; m_ovf = 0; m_fv = 0;
   endtask

   // Advance model by one clock using the inputs presented now, then clock DUT.
   task automatic tick();
      logic [31:0] r;
      ev_t e;
      r = state & ~m_prev;
      if (flush) begin
         m_q.delete();
         m_ovf = 0;
      end else begin
         if (pop && m_q.size() > 0) void'(m_q.pop_front());
         if (r != 0) begin
            if (m_q.size() < 16) begin
               e.mask = r; e.ts = m_ts; m_q.push_back(e);
            end else begin
               m_ovf = 1;
            end
         end
      end
      if (clr) begin m_fv = 0; m_fm = 0; m_ft = 0; end
      if (r != 0 && !m_fv) begin m_fv = 1; m_fm = r; m_ft = m_ts; end
      m_prev = state;
      m_ts   = m_ts + 1;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] head_mask();
      return (m_q.size() > 0) ? m_q[0].mask : 32'h0;
   endfunction
   function automatic logic [31:0] head_time();
      return (m_q.size() > 0) ? m_q[0].ts : 32'h0;
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      state = 0; clr = 0; flush = 0; pop = 0;
      rst_n = 0;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({ev_valid, ev_mask, ev_time, ev_count, overflow, first_valid, first_mask, first_time, timestamp} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: outputs=%h expected all zero",
                  {ev_valid, ev_mask, ev_time, ev_count, overflow, first_valid, first_mask, first_time, timestamp});
      end
      rst_n = 1;
   endtask

   task automatic test_first_event();
      repeat (10) tick();
      n_tests++;
      if (timestamp !== 32'd10) begin
         n_fail++; $display("FAIL ts_count: got %0d want 10", timestamp);
      end
      state = 32'h1;
      tick();
      n_tests++;
      if (ev_valid !== 1'b1 || ev_mask !== 32'h1 || ev_time !== 32'd10 || ev_count !== 5'd1) begin
         n_fail++;
         $display("FAIL first_entry: v=%0b mask=%h time=%0d cnt=%0d want 1/1/10/1", ev_valid, ev_mask, ev_time, ev_count);
      end
      n_tests++;
      if (first_valid !== 1'b1 || first_mask !== 32'h1 || first_time !== 32'd10) begin
         n_fail++;
         $display("FAIL first_fault: v=%0b mask=%h time=%0d want 1/1/10", first_valid, first_mask, first_time);
      end
   endtask

   task automatic test_sequence();
      logic [31:0] seq [4] = '{32'h3, 32'h3, 32'h0, 32'h2};
      for (int i = 0; i < 4; i++) begin
         state = seq[i];
         tick();
      end
      n_tests++;
      if (ev_count !== 5'd3) begin
         n_fail++; $display("FAIL seq_count: got %0d want 3", ev_count);
      end
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if (ev_mask !== ((i == 0) ? 32'h1 : 32'h2) || ev_time !== head_time()) begin
            n_fail++;
            $display("FAIL seq_entry%0d: mask=%h time=%0d want %h/%0d", i, ev_mask, ev_time,
                     (i == 0) ? 32'h1 : 32'h2, head_time());
         end
         pop = 1; tick(); pop = 0;
      end
      n_tests++;
      if (first_valid !== 1'b1 || first_mask !== 32'h1 || first_time !== 32'd10) begin
         n_fail++;
         $display("FAIL seq_first_hold: v=%0b mask=%h time=%0d want 1/1/10", first_valid, first_mask, first_time);
      end
      clr = 1; tick(); clr = 0;
      n_tests++;
      if (first_valid !== 1'b0 || first_mask !== 32'h0 || first_time !== 32'h0) begin
         n_fail++;
         $display("FAIL seq_clr: v=%0b mask=%h time=%0d want 0/0/0", first_valid, first_mask, first_time);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] t0;
      state = 0; flush = 1; tick(); flush = 0;
      t0 = m_ts;
      for (int i = 0; i < 17; i++) begin
         state = 32'h1 << i;
         tick();
      end
      n_tests++;
      if (ev_count !== 5'd16 || overflow !== 1'b1) begin
         n_fail++; $display("FAIL ovf_full: cnt=%0d ovf=%0b want 16/1", ev_count, overflow);
      end
      for (int i = 0; i < 16; i++) begin
         n_tests++;
         if (ev_valid !== 1'b1 || ev_mask !== (32'h1 << i) || ev_time !== t0 + i) begin
            n_fail++;
            $display("FAIL ovf_drain%0d: v=%0b mask=%h time=%0d want 1/%h/%0d", i, ev_valid, ev_mask, ev_time,
                     32'h1 << i, t0 + i);
         end
         pop = 1; tick(); pop = 0;
      end
      n_tests++;
      if (ev_valid !== 1'b0 || ev_count !== 5'd0 || ev_mask !== 32'h0 || overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_empty: v=%0b cnt=%0d mask=%h ovf=%0b want 0/0/0/1", ev_valid, ev_count, ev_mask, overflow);
      end
   endtask

   task automatic test_flush_pop_empty();
      for (int i = 0; i < 3; i++) begin
         state = 32'h100 << i;
         tick();
      end
      state = 32'h800; flush = 1; pop = 1;
      tick();
      flush = 0; pop = 0;
      n_tests++;
      if (ev_count !== 5'd0 || ev_valid !== 1'b0 || overflow !== 1'b0 || ev_mask !== 32'h0) begin
         n_fail++;
         $display("FAIL flush: cnt=%0d v=%0b ovf=%0b mask=%h want 0/0/0/0", ev_count, ev_valid, overflow, ev_mask);
      end
      pop = 1; tick(); pop = 0;
      n_tests++;
      if (ev_count !== 5'd0 || ev_valid !== 1'b0 || ev_time !== 32'h0 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL pop_empty: cnt=%0d v=%0b time=%0d ovf=%0b want 0/0/0/0", ev_count, ev_valid, ev_time, overflow);
      end
   endtask

   task automatic test_full_pop();
      state = 0; tick();
      for (int i = 0; i < 16; i++) begin
         state = 32'h1 << i;
         tick();
      end
      state = 32'h1 << 16; pop = 1;
      tick();
      pop = 0;
      n_tests++;
      if (ev_count !== 5'd16 || ev_mask !== 32'h2 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL full_pop: cnt=%0d mask=%h ovf=%0b want 16/2/0", ev_count, ev_mask, overflow);
      end
      for (int i = 0; i < 16; i++) begin
         n_tests++;
         if (ev_mask !== (32'h2 << i) || ev_time !== head_time()) begin
            n_fail++;
            $display("FAIL full_pop_drain%0d: mask=%h time=%0d want %h/%0d", i, ev_mask, ev_time, 32'h2 << i, head_time());
         end
         pop = 1; tick(); pop = 0;
      end
   endtask

   task automatic test_clr_capture();
      state = 0; tick();
      state = 32'h4; tick();
      n_tests++;
      if (first_valid !== 1'b1) begin
         n_fail++; $display("FAIL clr_pre: first_valid=%0b want 1", first_valid);
      end
      state = 32'hC; clr = 1;
      tick();
      clr = 0;
      n_tests++;
      if (first_valid !== 1'b1 || first_mask !== 32'h8 || first_time !== m_ts - 1) begin
         n_fail++;
         $display("FAIL clr_capture: v=%0b mask=%h time=%0d want 1/8/%0d", first_valid, first_mask, first_time, m_ts - 1);
      end
   endtask

   task automatic test_random(input int cycles, input int pop_pct);
      for (int c = 0; c < cycles; c++) begin
         state = $urandom & $urandom & $urandom;
         pop   = ($urandom_range(0, 99) < pop_pct);
         flush = ($urandom_range(0, 79) == 0);
         clr   = ($urandom_range(0, 24) == 0);
         tick();
         n_tests++;
         if (ev_valid !== (m_q.size() > 0) || ev_count !== m_q.size() || ev_mask !== head_mask() ||
             ev_time !== head_time() || overflow !== m_ovf || first_valid !== m_fv ||
             first_mask !== m_fm || first_time !== m_ft || timestamp !== m_ts) begin
            n_fail++;
            $display("FAIL random%0d: v=%0b cnt=%0d mask=%h time=%0d ovf=%0b fv=%0b fm=%h ft=%0d ts=%0d want %0b/%0d/%h/%0d/%0b/%0b/%h/%0d/%0d",
                     c, ev_valid, ev_count, ev_mask, ev_time, overflow, first_valid, first_mask, first_time, timestamp,
                     m_q.size() > 0, m_q.size(), head_mask(), head_time(), m_ovf, m_fv, m_fm, m_ft, m_ts);
         end
      end
      state = 0; pop = 0; flush = 0; clr = 0;
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) begin
         state = 32'h10000 << i;
         tick();
      end
      pop = 1; tick();
      #2;
      rst_n = 0;
      #1;
      n_tests++;
      if ({ev_valid, ev_mask, ev_time, ev_count, overflow, first_valid, first_mask, first_time, timestamp} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid: outputs=%h expected all zero",
                  {ev_valid, ev_mask, ev_time, ev_count, overflow, first_valid, first_mask, first_time, timestamp});
      end
      pop = 0; state = 0;
      model_clear();
      @(posedge clk); #3;
      rst_n = 1;
      state = 32'h5;
      tick();
      n_tests++;
      if (ev_count !== 5'd1 || ev_mask !== 32'h5 || ev_time !== 32'd0 || first_mask !== 32'h5) begin
         n_fail++;
         $display("FAIL reset_recover: cnt=%0d mask=%h time=%0d fm=%h want 1/5/0/5", ev_count, ev_mask, ev_time, first_mask);
      end
   endtask

   initial begin
      test_reset();
      test_first_event();
      test_sequence();
      test_overflow();
      test_flush_pop_empty();
      test_full_pop();
      test_clr_capture();
      test_random(300, 20);
      test_random(300, 70);
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/intl_fault_logger.md
# intl_fault_logger

Interlock event recorder sitting directly downstream of the interlock core, consuming its 32-bit interlock state word. Detects newly asserted interlock bits, timestamps each event with a free-running cycle counter, and buffers events in a FIFO for the PS to drain through the interlock AXI register block. Separately latches the first fault since the last interlock clear, for root-cause diagnosis.

## Interface

Parameters:
- DEPTH_LOG2, 4, FIFO depth = 2^DEPTH_LOG2 entries (16)
- TS_WIDTH, 32, timestamp counter width in bits

Ports:
- i_clk  in  1  system clock (same clock as the interlock core)
- i_rst  in  1  reset, asynchronous, active-low
- i_intl_state  in  32  interlock state word from interlock core (registered upstream)
- i_intl_clr  in  1  interlock clear pulse; re-arms first-fault capture
- i_log_flush  in  1  empties FIFO and clears overflow
- i_pop  in  1  single-cycle pulse: consume FIFO head
- o_ev_valid  out  1  FIFO non-empty
- o_ev_mask  out  32  head entry: bits that rose
- o_ev_time  out  TS_WIDTH  head entry: timestamp
- o_ev_count  out  DEPTH_LOG2+1  number of stored entries, 0..16
- o_overflow  out  1  sticky: an event was dropped because FIFO was full
- o_first_valid  out  1  first-fault registers hold a capture
- o_first_mask  out  32  rising bits of first fault
- o_first_time  out  TS_WIDTH  timestamp of first fault
- o_timestamp  out  TS_WIDTH  free-running counter value

## Operation

- Reset (i_rst low, asynchronous): every output and internal register = 0; FIFO empty; prev-state register = 0.
- Timestamp: increments by 1 every clock after reset release; wraps 2^TS_WIDTH-1 -> 0 without flag.
- Edge detect: rise = i_intl_state & ~prev_q; prev_q <= i_intl_state every clock (including during flush/clear). Falling edges not logged.
- Event: rise != 0. One entry per cycle; simultaneous bits share one entry (mask = rise, time = o_timestamp value at that clock edge).
- Write/pop per clock, priority order:
  - i_log_flush = 1: FIFO emptied, count = 0, o_overflow = 0; write and pop in same cycle discarded.
  - Else event and count < 16: entry written. Event and count = 16 with i_pop = 1: pop and write both occur, count stays 16. Event and count = 16 without pop: entry dropped, o_overflow <= 1.
  - i_pop with count = 0: ignored, no underflow.
- Head outputs: o_ev_mask / o_ev_time = head entry while o_ev_valid = 1; forced 0 when empty.
- Pointers wrap modulo 16; count derived independently so full and empty are unambiguous.
- First fault: when o_first_valid = 0 and event occurs, capture mask and time, set o_first_valid. Held through later events until i_intl_clr.
- i_intl_clr: clears o_first_valid/mask/time. If an event occurs in the same cycle as i_intl_clr, that event is captured as the new first fault (clear-then-capture). i_intl_clr does not affect FIFO or overflow.

## Timing

- Input sampled at edge k → FIFO entry, o_ev_valid, o_ev_count, first-fault registers all updated and visible after edge k (1-cycle latency, no extra pipeline).
- Entry time field = o_timestamp value presented before edge k.
- Pop at edge k → next head (or empty zeros) visible after edge k.
- Bit held high produces exactly one event; bit must go low then high again to re-log.
- Reset asserted mid-operation: immediate clear of all state, no partial write.

## Test plan

- Reset release, i_intl_state = 0x0000_0001 at timestamp 10 → o_ev_valid = 1, o_ev_mask = 0x1, o_ev_time = 10, o_first_mask = 0x1, o_first_time = 10, count = 1.
- State 0x1 → 0x3 → 0x3 → 0x0 → 0x2 over 5 cycles → two entries logged: 0x2, then 0x2 again; first fault unchanged until i_intl_clr pulse, then o_first_valid = 0.
- 17 distinct events without pop → count = 16, o_overflow = 1, entries 1..16 drain in order with correct timestamps; 17th absent.
- Full FIFO, event with i_pop same cycle → count stays 16, head advances, o_overflow stays 0.
- i_log_flush with event in same cycle → count = 0, o_ev_valid = 0, o_overflow = 0; pop on empty FIFO → no change.
- i_intl_clr coincident with rise 0x8 → o_first_valid = 1, o_first_mask = 0x8; async reset mid-drain → all outputs 0 immediately.
